regfile_r: RTL

//  Parametrised multi-entry register file, the successor to the single 8-bit

---
 rtl/regfile_r_pkg.sv | 13 +
 rtl/register_cell_r.sv | 29 ++
 rtl/regfile_r.sv | 91 +++++++++
 3 files changed

// File: rtl/regfile_r_pkg.sv
// Shared constants for the CPU register bank: default geometry and the
// named architectural register indices used by the decoder and testbench.
package regfile_r_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  localparam int REG_ACC = 0;
  localparam int REG_B   = 1;
  localparam int REG_IX  = 2;
  localparam int REG_SP  = 3;

endpackage

// File: rtl/register_cell_r.sv
// One register-file entry: WIDTH data flops plus a valid flag, with async
// reset, synchronous clear (priority over write) and write enable.
module register_cell_r #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q     <= RESET_VALUE;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= RESET_VALUE;
      valid <= 1'b0;
    end else if (we) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_r.sv
// Parametrised register file: one write port, two combinational read ports,
// optional write-to-read bypass, synchronous bulk clear and per-entry valid.
module regfile_r
  import regfile_r_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               DEPTH       = DEF_DEPTH,
  parameter int               BYPASS      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              AW          = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clear,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             valid_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             valid_b
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] q [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] cell_we;
  logic             bypass_on;

  // Out-of-range write addresses match no cell, so such writes drop naturally.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign cell_we[i] = we && !clear && (waddr == AW'(i));

    register_cell_r #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .we    (cell_we[i]),
      .clear (clear),
      .d     (wdata),
      .q     (q[i]),
      .valid (v[i])
    );
  end

  assign bypass_on = (BYPASS != 0) && we && !clear;

  always_comb begin
    rdata_a = '0;
    valid_a = 1'b0;
    if (reset) begin
      rdata_a = RESET_VALUE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr_a == AW'(i)) begin
          rdata_a = q[i];
          valid_a = v[i];
        end
      end
      if (bypass_on && (raddr_a == waddr) && ({1'b0, raddr_a} < DEPTH_W)) begin
        rdata_a = wdata;
        valid_a = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_b = '0;
    valid_b = 1'b0;
    if (reset) begin
      rdata_b = RESET_VALUE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr_b == AW'(i)) begin
          rdata_b = q[i];
          valid_b = v[i];
        end
      end
      if (bypass_on && (raddr_b == waddr) && ({1'b0, raddr_b} < DEPTH_W)) begin
        rdata_b = wdata;
        valid_b = 1'b1;
      end
    end
  end

endmodule
